// File: rtl/coherence_bus_arbiter.sv
// Multi-core coherence bus arbiter: round-robin grants of I/D cache requests onto one RAM
// port, with MSI-style snoop broadcast, cache-to-cache block transfer and multi-beat bursts.

package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module coherence_bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS  = 4,
  parameter int unsigned WORDS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0][31:0]  iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0]        ccwrite,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  dload,
  input  logic [CPUS-1:0]        cctrans,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS-1:0][31:0]  ccsnoopaddr,
  input  ramstate_t              ramstate,
  input  logic [31:0]            ramload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore
);

  localparam int unsigned OW = $clog2(CPUS);
  localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(WORDS - 1);
  localparam logic [OW-1:0] LAST_INIT = OW'(CPUS - 1);

  typedef enum logic [2:0] {IDLE, INV, SNOOP, SRESP, C2C, MEMRD, WB, IFETCH} state_t;

  state_t        state, next_state;
  logic [OW-1:0] owner, next_owner;
  logic [OW-1:0] supplier, next_supplier;
  logic [OW-1:0] last, next_last;
  logic [CW-1:0] cnt, next_cnt;

  logic [CPUS-1:0] dreq;
  logic            dfound, ifound, sfound;
  logic [OW-1:0]   dwin, iwin, swin;
  logic            snoop_en, snoop_inv, beat_done, access;

  function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int unsigned off);
    return OW'((32'(base) + off) % CPUS);
  endfunction

  assign dreq   = dREN | dWEN | ccwrite;
  assign access = (ramstate == ACCESS);

  // Round-robin scan starting one past the last granted core
  always_comb begin
    dfound = 1'b0;
    ifound = 1'b0;
    dwin   = '0;
    iwin   = '0;
    for (int unsigned i = 1; i <= CPUS; i++) begin
      if (!dfound && dreq[rr_idx(last, i)]) begin
        dfound = 1'b1;
        dwin   = rr_idx(last, i);
      end
      if (!ifound && iREN[rr_idx(last, i)]) begin
        ifound = 1'b1;
        iwin   = rr_idx(last, i);
      end
    end
  end

  // Lowest-index non-owner holding the block modified
  always_comb begin
    sfound = 1'b0;
    swin   = '0;
    for (int unsigned k = 0; k < CPUS; k++) begin
      if (!sfound && cctrans[OW'(k)] && (OW'(k) != owner)) begin
        sfound = 1'b1;
        swin   = OW'(k);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      owner    <= '0;
      supplier <= '0;
      last     <= LAST_INIT;
      cnt      <= '0;
    end else begin
      state    <= next_state;
      owner    <= next_owner;
      supplier <= next_supplier;
      last     <= next_last;
      cnt      <= next_cnt;
    end
  end

  always_comb begin
    next_state    = state;
    next_owner    = owner;
    next_supplier = supplier;
    next_last     = last;
    next_cnt      = cnt;
    iwait         = '1;
    dwait         = '1;
    iload         = '0;
    dload         = '0;
    ccwait        = '0;
    ccinv         = '0;
    ccsnoopaddr   = '0;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ramaddr       = '0;
    ramstore      = '0;
    snoop_en      = 1'b0;
    snoop_inv     = 1'b0;
    beat_done     = 1'b0;

    case (state)
      IDLE: begin
        next_cnt = '0;
        if (dfound) begin
          next_owner = dwin;
          next_last  = dwin;
          if (dWEN[dwin])      next_state = WB;
          else if (dREN[dwin]) next_state = SNOOP;
          else                 next_state = INV;
        end else if (ifound) begin
          next_owner = iwin;
          next_last  = iwin;
          next_state = IFETCH;
        end
      end

      INV: begin
        next_state = IDLE;
        if (ccwrite[owner]) begin
          snoop_en     = 1'b1;
          snoop_inv    = 1'b1;
          dwait[owner] = 1'b0;
        end
      end

      SNOOP, SRESP: begin
        if (!dREN[owner]) begin
          next_state = IDLE;
        end else begin
          snoop_en  = 1'b1;
          snoop_inv = ccwrite[owner];
          if (state == SNOOP) begin
            next_state = SRESP;
          end else if (sfound) begin
            next_supplier = swin;
            next_state    = C2C;
          end else begin
            next_state = MEMRD;
          end
        end
      end

      C2C: begin
        if (!dREN[owner]) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          snoop_en     = 1'b1;
          snoop_inv    = ccwrite[owner];
          ramWEN       = 1'b1;
          ramaddr      = daddr[owner];
          ramstore     = dstore[supplier];
          dload[owner] = dstore[supplier];
          if (access) begin
            dwait[owner]    = 1'b0;
            dwait[supplier] = 1'b0;
            beat_done       = 1'b1;
          end
        end
      end

      MEMRD: begin
        if (!dREN[owner]) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          snoop_en  = 1'b1;
          snoop_inv = ccwrite[owner];
          ramREN    = 1'b1;
          ramaddr   = daddr[owner];
          if (access) begin
            dload[owner] = ramload;
            dwait[owner] = 1'b0;
            beat_done    = 1'b1;
          end
        end
      end

      WB: begin
        if (!dWEN[owner]) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[owner];
          ramstore = dstore[owner];
          if (access) begin
            dwait[owner] = 1'b0;
            beat_done    = 1'b1;
          end
        end
      end

      IFETCH: begin
        if (!iREN[owner]) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr[owner];
          if (access) begin
            iload[owner] = ramload;
            iwait[owner] = 1'b0;
            next_state   = IDLE;
          end
        end
      end

      default: next_state = IDLE;
    endcase

    // Burst bookkeeping; final beat returns to arbitration
    if (beat_done) begin
      if (cnt == LAST_BEAT) begin
        next_state = IDLE;
        next_cnt   = '0;
      end else begin
        next_cnt = cnt + CW'(1);
      end
    end

    if (snoop_en) begin
      for (int unsigned k = 0; k < CPUS; k++) begin
        if (OW'(k) != owner) begin
          ccwait[OW'(k)]      = 1'b1;
          ccinv[OW'(k)]       = snoop_inv;
          ccsnoopaddr[OW'(k)] = daddr[owner];
        end
      end
    end
  end

endmodule
